// File: rtl/sdr_sdram_wb_arb2_if.sv
// sdr_sdram_wb_arb2_if
// Signal bundle around the two-master Wishbone arbiter in front of the SDR
// SDRAM controller. Each master port and the controller-facing port is named
// from the arbiter's point of view.
//   m0_* / m1_* : dat_i[31:0], adr_i[adr_width:1], sel_i[3:0], cti_i[2:0],
//                 bte_i[1:0], we_i, cyc_i, stb_i    (into the arbiter)
//                 dat_o[31:0], ack_o                (out of the arbiter)
//   s_*         : dat_o, adr_o, sel_o, bte_o, we_o, cyc_o, stb_o (to controller)
//                 dat_i[31:0], ack_i                 (from controller)
// Modports:
//   slave  - the arbiter (it is the Wishbone slave both masters talk to).
//   master - the surrounding system: both masters plus the controller.
interface sdr_sdram_wb_arb2_if #(
    parameter int adr_width = 24
);
    logic [31:0]        m0_dat_i, m1_dat_i;
    logic [adr_width:1] m0_adr_i, m1_adr_i;
    logic [3:0]         m0_sel_i, m1_sel_i;
    logic [2:0]         m0_cti_i, m1_cti_i;
    logic [1:0]         m0_bte_i, m1_bte_i;
    logic               m0_we_i,  m1_we_i;
    logic               m0_cyc_i, m1_cyc_i;
    logic               m0_stb_i, m1_stb_i;
    logic [31:0]        m0_dat_o, m1_dat_o;
    logic               m0_ack_o, m1_ack_o;

    logic [31:0]        s_dat_o;
    logic [adr_width:1] s_adr_o;
    logic [3:0]         s_sel_o;
    logic [1:0]         s_bte_o;
    logic               s_we_o, s_cyc_o, s_stb_o;
    logic [31:0]        s_dat_i;
    logic               s_ack_i;

    modport slave (
        input  m0_dat_i, m0_adr_i, m0_sel_i, m0_cti_i, m0_bte_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m1_dat_i, m1_adr_i, m1_sel_i, m1_cti_i, m1_bte_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
        output s_dat_o, s_adr_o, s_sel_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m0_dat_i, m0_adr_i, m0_sel_i, m0_cti_i, m0_bte_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m1_dat_i, m1_adr_i, m1_sel_i, m1_cti_i, m1_bte_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
        input  s_dat_o, s_adr_o, s_sel_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/sdr_sdram_wb_arb2.sv
// sdr_sdram_wb_arb2
// Two-master Wishbone B3 arbiter feeding the 16-bit SDR SDRAM controller.
// Round-robin at Wishbone cycle boundaries (bursts are never split), a limit
// of hold_max back-to-back cycles while the other master waits, and a dead
// cycle on every grant change so the controller sees a clean request edge.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - sdr_sdram_wb_arb2_if.slave: m0_*/m1_* master ports, s_* controller port
// Parameters:
//   adr_width - word address width, bus spans [adr_width:1]
//   hold_max  - completed cycles one master may chain while the other requests
module sdr_sdram_wb_arb2 #(
    parameter int adr_width = 24,
    parameter int hold_max  = 4
) (
    input  logic               clk,
    input  logic               rst,
    sdr_sdram_wb_arb2_if.slave bus
);
    localparam int                cnt_w     = $clog2(hold_max + 1);
    localparam logic [cnt_w-1:0]  hold_lim  = cnt_w'(hold_max);
    localparam logic [cnt_w-1:0]  hold_last = cnt_w'(hold_max - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

    state_t           state, state_d;
    logic             last_gnt, last_gnt_d;
    logic [cnt_w-1:0] hold_cnt, hold_cnt_d;
    // Set for the one cycle after a completed cycle in which the owner kept
    // the grant. If the owner has dropped cyc in that cycle, the cycle itself
    // is the dead cycle, so the boundary-to-new-stb turnaround stays at 3.
    logic             post_bnd, post_bnd_d;

    logic             req0, req1, gnt0, gnt1;
    logic             own_cyc, oth_req, live, boundary;
    logic [2:0]       own_cti;
    logic [adr_width:1] adr_mux;

    assign req0    = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1    = bus.m1_cyc_i & bus.m1_stb_i;
    assign gnt0    = (state == GNT0);
    assign gnt1    = (state == GNT1);
    assign own_cyc = gnt1 ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign own_cti = gnt1 ? bus.m1_cti_i : bus.m0_cti_i;
    assign oth_req = gnt1 ? req0 : req1;
    // The controller port is connected only while a granted master holds cyc.
    assign live    = (gnt0 | gnt1) & own_cyc;
    // Classic cycle or last beat of a burst; incrementing beats never end a cycle.
    assign boundary = live & bus.s_ack_i & ((own_cti == 3'b000) | (own_cti == 3'b111));

    // NOTE: non-blocking assignments here so every register updates from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            hold_cnt <= '0;
            post_bnd <= 1'b0;
        end else begin
            state    <= state_d;
            last_gnt <= last_gnt_d;
            hold_cnt <= hold_cnt_d;
            post_bnd <= post_bnd_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state;
        last_gnt_d = last_gnt;
        hold_cnt_d = hold_cnt;
        post_bnd_d = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (req0 && (!req1 || last_gnt)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_cyc) begin
                    // Owner released the bus: after a boundary this cycle
                    // already served as the gap, otherwise it is an abort.
                    last_gnt_d = gnt1;
                    hold_cnt_d = '0;
                    state_d    = post_bnd ? IDLE : GAP;
                end else if (boundary) begin
                    if (oth_req && (hold_cnt >= hold_last)) begin
                        last_gnt_d = gnt1;
                        hold_cnt_d = '0;
                        state_d    = GAP;
                    end else begin
                        hold_cnt_d = (hold_cnt == hold_lim) ? hold_cnt : hold_cnt + cnt_w'(1);
                        post_bnd_d = 1'b1;
                    end
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        adr_mux      = '0;
        bus.s_dat_o  = '0;
        bus.s_sel_o  = '0;
        bus.s_bte_o  = '0;
        bus.s_we_o   = 1'b0;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        if (live && gnt0) begin
            adr_mux      = bus.m0_adr_i;
            bus.s_dat_o  = bus.m0_dat_i;
            bus.s_sel_o  = bus.m0_sel_i;
            bus.s_bte_o  = bus.m0_bte_i;
            bus.s_we_o   = bus.m0_we_i;
            bus.s_cyc_o  = bus.m0_cyc_i;
            bus.s_stb_o  = bus.m0_stb_i;
            bus.m0_ack_o = bus.s_ack_i;
        end else if (live && gnt1) begin
            adr_mux      = bus.m1_adr_i;
            bus.s_dat_o  = bus.m1_dat_i;
            bus.s_sel_o  = bus.m1_sel_i;
            bus.s_bte_o  = bus.m1_bte_i;
            bus.s_we_o   = bus.m1_we_i;
            bus.s_cyc_o  = bus.m1_cyc_i;
            bus.s_stb_o  = bus.m1_stb_i;
            bus.m1_ack_o = bus.s_ack_i;
        end
    end

    assign bus.s_adr_o  = adr_mux;
    // Read data fans out ungated; only the ack qualifies it.
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
endmodule

// File: tb/tb_sdr_sdram_wb_arb2.sv
// tb_sdr_sdram_wb_arb2
// Directed scenarios for the two-master arbiter followed by randomized
// traffic checked against a transaction-order reference model.
module tb_sdr_sdram_wb_arb2;
    localparam int aw = 24;
    localparam int hm = 4;

    typedef struct {
        logic [aw:1] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } tx_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    sdr_sdram_wb_arb2_if #(.adr_width(aw)) ifc ();

    sdr_sdram_wb_arb2 #(.adr_width(aw), .hold_max(hm)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m(input int n, input logic cs, input logic we, input logic [2:0] cti,
                           input logic [1:0] bte, input logic [aw:1] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        if (n == 0) begin
            ifc.m0_cyc_i = cs;  ifc.m0_stb_i = cs;  ifc.m0_we_i = we;  ifc.m0_cti_i = cti;
            ifc.m0_bte_i = bte; ifc.m0_adr_i = adr; ifc.m0_dat_i = dat; ifc.m0_sel_i = sel;
        end else begin
            ifc.m1_cyc_i = cs;  ifc.m1_stb_i = cs;  ifc.m1_we_i = we;  ifc.m1_cti_i = cti;
            ifc.m1_bte_i = bte; ifc.m1_adr_i = adr; ifc.m1_dat_i = dat; ifc.m1_sel_i = sel;
        end
    endtask

    task automatic release_m(input int n);
        drive_m(n, 1'b0, 1'b0, 3'b000, 2'b00, '0, '0, '0);
    endtask

    // Holds reset for two cycles, checks the reset outputs, and returns at a
    // falling edge with reset released.
    task automatic do_reset();
        release_m(0);
        release_m(1);
        ifc.s_ack_i = 1'b0;
        ifc.s_dat_i = 32'h1234_5678;
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_s_cyc", ifc.s_cyc_o, 0);
        check("rst_s_stb", ifc.s_stb_o, 0);
        check("rst_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b00);
        check("rst_m0_dat", ifc.m0_dat_o, 32'h1234_5678);
        check("rst_m1_dat", ifc.m1_dat_o, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          n_ack0;
        tx_t         q0[$];
        tx_t         q1[$];
        int          exp_seq[$];
        tx_t         tx;
        tx_t         h;
        int          n0, n1, r0, r1, rc, ro, cur, k, e;
        int          last_ack;
        logic        prev_stb, have_ack;

        // Single master classic write.
        do_reset();
        drive_m(0, 1'b1, 1'b1, 3'b000, 2'b00, 24'h000100, 32'hDEAD_BEEF, 4'hF);
        #1 check("t1_idle_stb", ifc.s_stb_o, 0);
        @(negedge clk); #1;
        check("t1_stb", ifc.s_stb_o, 1);
        check("t1_cyc", ifc.s_cyc_o, 1);
        check("t1_adr", ifc.s_adr_o, 24'h000100);
        check("t1_dat", ifc.s_dat_o, 32'hDEAD_BEEF);
        check("t1_sel", ifc.s_sel_o, 4'hF);
        check("t1_we", ifc.s_we_o, 1);
        ifc.s_ack_i = 1'b1;
        #1 check("t1_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b01);
        @(negedge clk);
        release_m(0);
        ifc.s_ack_i = 1'b0;
        #1 check("t1_gap_cyc", ifc.s_cyc_o, 0);
        @(negedge clk); #1 check("t1_idle_cyc", ifc.s_cyc_o, 0);

        // Simultaneous request from reset: m0 first, m1 three cycles after m0's ack.
        do_reset();
        drive_m(0, 1'b1, 1'b0, 3'b000, 2'b00, 24'h000200, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b0, 3'b000, 2'b00, 24'h000300, 32'h0, 4'hF);
        @(negedge clk); #1;
        check("t2_first_adr", ifc.s_adr_o, 24'h000200);
        ifc.s_ack_i = 1'b1;
        #1 check("t2_first_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b01);
        @(negedge clk);
        release_m(0);
        ifc.s_ack_i = 1'b0;
        #1 check("t2_ack_p1_stb", ifc.s_stb_o, 0);
        @(negedge clk); #1 check("t2_ack_p2_stb", ifc.s_stb_o, 0);
        @(negedge clk); #1;
        check("t2_ack_p3_stb", ifc.s_stb_o, 1);
        check("t2_second_adr", ifc.s_adr_o, 24'h000300);
        ifc.s_ack_i = 1'b1;
        #1 check("t2_second_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b10);
        @(negedge clk);
        release_m(1);
        ifc.s_ack_i = 1'b0;

        // m1 4-beat incrementing read burst while m0 waits.
        do_reset();
        drive_m(1, 1'b1, 1'b0, 3'b010, 2'b01, 24'h000400, 32'h0, 4'hF);
        @(negedge clk);
        drive_m(0, 1'b1, 1'b1, 3'b000, 2'b00, 24'h000500, 32'hA5A5_A5A5, 4'h3);
        for (int b = 0; b < 4; b++) begin
            drive_m(1, 1'b1, 1'b0, (b == 3) ? 3'b111 : 3'b010, 2'b01,
                    24'(32'h400 + b), 32'h0, 4'hF);
            ifc.s_ack_i = 1'b1;
            rd = $urandom;
            ifc.s_dat_i = rd;
            #1;
            check("t3_burst_adr", ifc.s_adr_o, 24'(32'h400 + b));
            check("t3_burst_bte", ifc.s_bte_o, 2'b01);
            check("t3_burst_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b10);
            check("t3_burst_rdat", ifc.m1_dat_o, rd);
            @(negedge clk);
        end
        release_m(1);
        ifc.s_ack_i = 1'b0;
        #1 check("t3_gap_cyc", ifc.s_cyc_o, 0);
        @(negedge clk); #1 check("t3_idle_cyc", ifc.s_cyc_o, 0);
        @(negedge clk); #1;
        check("t3_m0_stb", ifc.s_stb_o, 1);
        check("t3_m0_adr", ifc.s_adr_o, 24'h000500);
        check("t3_m0_sel", ifc.s_sel_o, 4'h3);
        ifc.s_ack_i = 1'b1;
        #1 check("t3_m0_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b01);
        @(negedge clk);
        release_m(0);
        ifc.s_ack_i = 1'b0;

        // Fairness: m0 chains classic cycles while m1 waits.
        do_reset();
        drive_m(0, 1'b1, 1'b1, 3'b000, 2'b00, 24'h000600, 32'h0, 4'hF);
        @(negedge clk);
        drive_m(1, 1'b1, 1'b0, 3'b000, 2'b00, 24'h000700, 32'h0, 4'hF);
        n_ack0 = 0;
        for (int j = 0; j < hm; j++) begin
            drive_m(0, 1'b1, 1'b1, 3'b000, 2'b00, 24'(32'h600 + j), 32'(j), 4'hF);
            ifc.s_ack_i = 1'b1;
            #1 check("t4_m0_adr", ifc.s_adr_o, 24'(32'h600 + j));
            if (ifc.m0_ack_o) n_ack0++;
            @(negedge clk);
        end
        check("t4_m0_ack_count", n_ack0, hm);
        #1;
        check("t4_gap_cyc", ifc.s_cyc_o, 0);
        check("t4_gap_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b00);
        @(negedge clk);
        ifc.s_ack_i = 1'b0;
        #1 check("t4_idle_cyc", ifc.s_cyc_o, 0);
        @(negedge clk); #1;
        check("t4_m1_adr", ifc.s_adr_o, 24'h000700);
        ifc.s_ack_i = 1'b1;
        #1 check("t4_m1_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b10);
        @(negedge clk);
        release_m(1);
        ifc.s_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("t4_m0_regrant_adr", ifc.s_adr_o, 24'h000603);
        check("t4_m0_regrant_stb", ifc.s_stb_o, 1);
        @(negedge clk);
        release_m(0);

        // Abort before any ack, then a spurious ack in the gap and in idle.
        do_reset();
        drive_m(1, 1'b1, 1'b0, 3'b000, 2'b00, 24'h000800, 32'h0, 4'hF);
        @(negedge clk); #1 check("t5_granted_stb", ifc.s_stb_o, 1);
        @(negedge clk);
        release_m(1);
        #1 check("t5_abort_cyc", ifc.s_cyc_o, 0);
        @(negedge clk);
        ifc.s_ack_i = 1'b1;
        #1;
        check("t5_gap_cyc", ifc.s_cyc_o, 0);
        check("t5_gap_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b00);
        @(negedge clk); #1;
        check("t5_idle_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b00);
        check("t5_idle_stb", ifc.s_stb_o, 0);
        ifc.s_ack_i = 1'b0;

        // Asynchronous reset in the middle of an m0 burst.
        do_reset();
        drive_m(0, 1'b1, 1'b0, 3'b010, 2'b01, 24'h000900, 32'h0, 4'hF);
        @(negedge clk);
        ifc.s_ack_i = 1'b1;
        #1 check("t6_beat0_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b01);
        @(negedge clk);
        drive_m(0, 1'b1, 1'b0, 3'b010, 2'b01, 24'h000901, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b0, 3'b000, 2'b00, 24'h000A00, 32'h0, 4'hF);
        #1 check("t6_beat1_acks", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_cyc", ifc.s_cyc_o, 0);
        check("t6_rst_stb", ifc.s_stb_o, 0);
        check("t6_rst_m0_ack", ifc.m0_ack_o, 0);
        ifc.s_ack_i = 1'b0;
        drive_m(0, 1'b1, 1'b0, 3'b000, 2'b00, 24'h000B00, 32'h0, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        #1 check("t6_idle_stb", ifc.s_stb_o, 0);
        @(negedge clk); #1;
        check("t6_tie_adr", ifc.s_adr_o, 24'h000B00);
        check("t6_tie_acks_idle", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b00);
        release_m(0);
        release_m(1);

        // Randomized traffic: both masters start together with a random number
        // of classic cycles; the model predicts the order of completed cycles.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            q0.delete();
            q1.delete();
            exp_seq.delete();
            n0 = $urandom_range(1, 9);
            n1 = $urandom_range(1, 9);
            for (int i = 0; i < n0 + n1; i++) begin
                tx.adr = 24'($urandom);
                tx.dat = $urandom;
                tx.sel = 4'($urandom);
                tx.we  = 1'($urandom);
                if (i < n0) q0.push_back(tx);
                else        q1.push_back(tx);
            end
            // Round robin starting with m0; an owner keeps the bus for at most
            // hm cycles while the other still has work, else until it is done.
            r0 = n0;
            r1 = n1;
            cur = 0;
            while (r0 + r1 > 0) begin
                rc = (cur == 1) ? r1 : r0;
                ro = (cur == 1) ? r0 : r1;
                if (rc > 0) begin
                    k = (ro > 0 && rc > hm) ? hm : rc;
                    repeat (k) exp_seq.push_back(cur);
                    if (cur == 1) r1 -= k;
                    else          r0 -= k;
                end
                cur = 1 - cur;
            end

            prev_stb = 1'b0;
            have_ack = 1'b0;
            last_ack = 0;
            for (int t = 0; t < 400 && (q0.size() + q1.size()) > 0; t++) begin
                if (q0.size() > 0) drive_m(0, 1'b1, q0[0].we, 3'b000, 2'b00, q0[0].adr, q0[0].dat, q0[0].sel);
                else               release_m(0);
                if (q1.size() > 0) drive_m(1, 1'b1, q1[0].we, 3'b000, 2'b00, q1[0].adr, q1[0].dat, q1[0].sel);
                else               release_m(1);
                ifc.s_ack_i = 1'b0;
                #1;
                ifc.s_dat_i = $urandom;
                if (ifc.s_stb_o) begin
                    if (!prev_stb && have_ack) check("rr_turnaround", t - last_ack, 3);
                    ifc.s_ack_i = ($urandom_range(0, 1) == 1);
                end else begin
                    ifc.s_ack_i = ($urandom_range(0, 3) == 0);
                end
                #1;
                if (ifc.s_ack_i && !ifc.s_stb_o) begin
                    check("rr_spurious", {ifc.m1_ack_o, ifc.m0_ack_o}, 2'b00);
                end else if (ifc.s_ack_i) begin
                    if (exp_seq.size() == 0) begin
                        check("rr_seq_left", exp_seq.size(), 1);
                    end else begin
                        e = exp_seq.pop_front();
                        if (e == 1) h = q1[0];
                        else        h = q0[0];
                        check("rr_owner", {ifc.m1_ack_o, ifc.m0_ack_o}, (e == 1) ? 2'b10 : 2'b01);
                        check("rr_adr", ifc.s_adr_o, h.adr);
                        check("rr_dat", ifc.s_dat_o, h.dat);
                        check("rr_sel", ifc.s_sel_o, h.sel);
                        check("rr_we", ifc.s_we_o, h.we);
                        check("rr_rdat", (e == 1) ? ifc.m1_dat_o : ifc.m0_dat_o, ifc.s_dat_i);
                        if (e == 1) void'(q1.pop_front());
                        else        void'(q0.pop_front());
                        have_ack = 1'b1;
                        last_ack = t;
                    end
                end
                prev_stb = ifc.s_stb_o;
                @(negedge clk);
            end
            check("rr_drained", q0.size() + q1.size(), 0);
            check("rr_seq_done", exp_seq.size(), 0);
        end

        release_m(0);
        release_m(1);
        ifc.s_ack_i = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
